onehot_decoder_pipe: RTL and testbench

Parametrised, flow-controlled successor to the registered one-hot decoder. It accepts a binary index over a valid/ready handshake and decodes it in one of four vector modes. The result is registered behind a 2-entry skid stage, giving full throughput with registered `in_ready`. It also flags indices outside the output width and keeps a saturating error count. It sits between index producers (arbiters, address decoders, channel selectors) and consumers that need per-lane enables under backpressure.

---
 rtl/onehot_decoder_pkg.sv | 8 +
 rtl/onehot_decode_comb.sv | 26 ++
 rtl/onehot_decoder_pipe.sv | 77 +++++++
 tb/tb_onehot_decoder_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pkg.sv
// onehot_decoder_pkg: decode mode codes and skid-pipeline occupancy states.
package onehot_decoder_pkg;
    localparam logic [1:0] MODE_ONEHOT    = 2'd0;
    localparam logic [1:0] MODE_THERMO    = 2'd1;
    localparam logic [1:0] MODE_ONEHOT_N  = 2'd2;
    localparam logic [1:0] MODE_THERMO_HI = 2'd3;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;
endpackage

// File: rtl/onehot_decode_comb.sv
// onehot_decode_comb: combinational index-to-vector decode in four modes with range flag.
module onehot_decode_comb
    import onehot_decoder_pkg::*;
#(
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 16
) (
    input  logic [INPUT_WIDTH-1:0]  index,
    input  logic [1:0]              mode,
    output logic [OUTPUT_WIDTH-1:0] vec,
    output logic                    err
);
    localparam logic [OUTPUT_WIDTH-1:0] ONE = OUTPUT_WIDTH'(1);
    logic [OUTPUT_WIDTH-1:0] hot, below;
    // below holds bits 0..i-1; every mode is hot/below combined or inverted
    always_comb begin
        err   = 32'(index) >= OUTPUT_WIDTH;
        hot   = ONE << index;
        below = hot - ONE;
        vec   = err                    ? '0 :
                mode == MODE_ONEHOT    ? hot :
                mode == MODE_THERMO    ? (below | hot) :
                mode == MODE_ONEHOT_N  ? ~hot :
                mode == MODE_THERMO_HI ? ~below : '0;
    end
endmodule

// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe: valid/ready one-hot decoder with 2-entry skid buffer,
// registered in_ready and saturating out-of-range counter.
module onehot_decoder_pipe
    import onehot_decoder_pkg::*;
#(
    parameter int INPUT_WIDTH   = 4,
    parameter int OUTPUT_WIDTH  = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INPUT_WIDTH-1:0]   in_index,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUTPUT_WIDTH-1:0]  out_vec,
    output logic                     out_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);
    if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > 2**INPUT_WIDTH) begin : g_bad_width
        $error("onehot_decoder_pipe: OUTPUT_WIDTH must be within 1..2**INPUT_WIDTH");
    end
    state_t state;
    logic [OUTPUT_WIDTH-1:0] dec_vec, skid_vec;
    logic dec_err, skid_err, in_xfer, out_xfer;
    onehot_decode_comb #(.INPUT_WIDTH(INPUT_WIDTH), .OUTPUT_WIDTH(OUTPUT_WIDTH)) u_dec (
        .index(in_index),
        .mode (in_mode),
        .vec  (dec_vec),
        .err  (dec_err)
    );
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    // in_ready/out_valid are registered copies of the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (in_xfer && dec_err && err_count != '1)
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            case (state)
                ST_EMPTY: if (in_xfer) begin
                    out_vec   <= dec_vec;
                    out_err   <= dec_err;
                    out_valid <= 1'b1;
                    state     <= ST_ONE;
                end
                ST_ONE: if (in_xfer && !out_xfer) begin
                    skid_vec <= dec_vec;
                    skid_err <= dec_err;
                    in_ready <= 1'b0;
                    state    <= ST_FULL;
                end else if (out_xfer && !in_xfer) begin
                    out_valid <= 1'b0;
                    state     <= ST_EMPTY;
                end else if (in_xfer) begin
                    out_vec <= dec_vec;
                    out_err <= dec_err;
                end
                ST_FULL: if (out_xfer) begin
                    out_vec  <= skid_vec;
                    out_err  <= skid_err;
                    in_ready <= 1'b1;
                    state    <= ST_ONE;
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb_onehot_decoder_pipe: scoreboard bench for a 16-wide and a 12-wide decoder pipe.
module tb_onehot_decoder_pipe;
    logic clk = 0, rst = 1;
    logic in_valid = 0, out_ready = 0, in_ready, out_valid, out_err;
    logic [3:0] in_index = 0;
    logic [1:0] in_mode = 0;
    logic [15:0] out_vec;
    logic [7:0] err_count;
    logic b_in_valid = 0, b_out_ready = 0, b_in_ready, b_out_valid, b_out_err;
    logic [3:0] b_in_index = 0;
    logic [1:0] b_in_mode = 0;
    logic [11:0] b_out_vec;
    logic [7:0] b_err_count;
    int checks = 0, errors = 0, cyc = 0, m_err_b = 0;
    logic [16:0] q16[$], q12[$];
    logic [16:0] e16, e12;
    bit stream_done;

    onehot_decoder_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_err(out_err), .err_count(err_count)
    );
    onehot_decoder_pipe #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(12), .ERR_CNT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_index(b_in_index),
        .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec),
        .out_err(b_out_err), .err_count(b_err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference: per-bit evaluation of the mode rules, {err, vec}
    function automatic logic [16:0] model(int ow, int idx, int mode);
        logic [16:0] r = '0;
        if (idx >= ow) return {1'b1, 16'h0};
        for (int b = 0; b < ow; b++)
            r[b] = (mode == 0) ? (b == idx) : (mode == 1) ? (b <= idx) :
                   (mode == 2) ? (b != idx) : (b >= idx);
        return r;
    endfunction

    always @(negedge clk) if (!rst) begin
        if (out_valid && out_ready) begin
            checks++;
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL out16_extra: got vec=%h err=%b, no item expected", out_vec, out_err);
            end else begin
                e16 = q16.pop_front();
                if ({out_err, out_vec} !== e16) begin
                    errors++;
                    $display("FAIL out16_item: got err=%b vec=%h, want err=%b vec=%h",
                             out_err, out_vec, e16[16], e16[15:0]);
                end
            end
        end
        if (in_valid && in_ready) q16.push_back(model(16, int'(in_index), int'(in_mode)));
    end

    always @(negedge clk) if (!rst) begin
        if (b_out_valid && b_out_ready) begin
            checks++;
            if (q12.size() == 0) begin
                errors++;
                $display("FAIL out12_extra: got vec=%h err=%b, no item expected", b_out_vec, b_out_err);
            end else begin
                e12 = q12.pop_front();
                if ({b_out_err, b_out_vec} !== {e12[16], e12[11:0]}) begin
                    errors++;
                    $display("FAIL out12_item: got err=%b vec=%h, want err=%b vec=%h",
                             b_out_err, b_out_vec, e12[16], e12[11:0]);
                end
            end
        end
        if (b_in_valid && b_in_ready) begin
            q12.push_back(model(12, int'(b_in_index), int'(b_in_mode)));
            if (int'(b_in_index) >= 12 && m_err_b < 255) m_err_b++;
        end
    end

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        q16.delete();
        q12.delete();
        m_err_b = 0;
    endtask

    task automatic send(input int idx, input int mode);
        int n = 0;
        in_valid = 1; in_index = 4'(idx); in_mode = 2'(mode);
        forever begin
            @(negedge clk);
            if (in_ready) begin @(posedge clk); #1; break; end
            if (++n > 1000) begin
                checks++; errors++;
                $display("FAIL send16_timeout: in_ready stayed %b, want 1", in_ready);
                break;
            end
        end
        in_valid = 0;
    endtask

    task automatic send_b(input int idx, input int mode);
        int n = 0;
        b_in_valid = 1; b_in_index = 4'(idx); b_in_mode = 2'(mode);
        forever begin
            @(negedge clk);
            if (b_in_ready) begin @(posedge clk); #1; break; end
            if (++n > 1000) begin
                checks++; errors++;
                $display("FAIL send12_timeout: in_ready stayed %b, want 1", b_in_ready);
                break;
            end
        end
        b_in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q16.size() != 0 || q12.size() != 0) begin
            @(negedge clk);
            if (++n > 500) begin
                checks++; errors++;
                $display("FAIL drain_timeout: %0d/%0d items left, want 0", q16.size(), q12.size());
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks += 5;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        if (out_vec !== 16'h0) begin errors++; $display("FAIL rst_out_vec: got %h want 0000", out_vec); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err: got %b want 0", out_err); end
        out_ready = 1;
        send(5, 0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", out_valid); end
        if (out_vec !== 16'h0020) begin errors++; $display("FAIL first_vec: got %h want 0020", out_vec); end
        drain();
    endtask

    task automatic test_modes();
        int idx[5] = '{5, 5, 5, 0, 15};
        int md[5] = '{1, 2, 3, 3, 1};
        logic [15:0] want[5] = '{16'h003F, 16'hFFDF, 16'hFFE0, 16'hFFFF, 16'hFFFF};
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            send(idx[k], md[k]);
            checks++;
            if (out_vec !== want[k] || out_err !== 1'b0) begin
                errors++;
                $display("FAIL mode_%0d_idx_%0d: got %h err=%b want %h err=0", md[k], idx[k], out_vec, out_err, want[k]);
            end
        end
        drain();
    endtask

    task automatic test_out_of_range();
        b_out_ready = 1;
        send_b(13, 1);
        checks += 2;
        if (b_out_vec !== 12'h000 || b_out_err !== 1'b1) begin
            errors++; $display("FAIL oor_item: got %h err=%b want 000 err=1", b_out_vec, b_out_err);
        end
        if (b_err_count !== 8'd1) begin errors++; $display("FAIL oor_count1: got %0d want 1", b_err_count); end
        send_b(11, 3);
        checks++;
        if (b_out_vec !== 12'h800 || b_out_err !== 1'b0) begin
            errors++; $display("FAIL edge_item: got %h err=%b want 800 err=0", b_out_vec, b_out_err);
        end
        for (int k = 0; k < 300; k++) send_b($urandom_range(12, 15), $urandom_range(0, 3));
        drain();
        checks += 2;
        if (b_err_count !== 8'd255) begin errors++; $display("FAIL oor_saturate: got %0d want 255", b_err_count); end
        if (b_err_count !== 8'(m_err_b)) begin errors++; $display("FAIL oor_model: got %0d want %0d", b_err_count, m_err_b); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        out_ready = 0;
        in_valid = 1; in_mode = 0;
        in_index = 1; @(posedge clk); #1;
        in_index = 2; @(posedge clk); #1;
        in_index = 3;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got %b want 0", in_ready); end
        if (out_vec !== 16'h0002 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_stable: got %h valid=%b want 0002 valid=1", out_vec, out_valid);
        end
        out_ready = 1;
        forever begin
            @(negedge clk);
            if (in_ready) begin @(posedge clk); #1; break; end
            if (++n > 100) begin checks++; errors++; $display("FAIL bp_stuck: in_ready %b want 1", in_ready); break; end
        end
        in_valid = 0;
        drain();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: out_valid %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        int c0;
        stream_done = 0;
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send($urandom_range(0, 15), $urandom_range(0, 3));
                end
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1;
        drain();
        c0 = cyc;
        for (int k = 0; k < 20; k++) send(k % 16, k % 4);
        checks++;
        if (cyc - c0 != 20) begin errors++; $display("FAIL throughput: got %0d cycles want 20", cyc - c0); end
        drain();
    endtask

    task automatic test_back_to_back_reset();
        out_ready = 0; b_out_ready = 0;
        send(4, 0);
        send(6, 1);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full: in_ready %b want 0", in_ready); end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        q16.delete(); q12.delete(); m_err_b = 0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        if (b_err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count: got %0d want 0", b_err_count); end
        out_ready = 1;
        send(7, 0);
        checks++;
        if (out_vec !== 16'h0080) begin errors++; $display("FAIL mid_first: got %h want 0080", out_vec); end
        drain();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_modes();
        test_out_of_range();
        test_backpressure();
        test_streaming();
        test_back_to_back_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
